cmd_seq_player: RTL

Command-sequence engine sitting directly upstream of RemoteComm. It replaces hand-coded SendCMD/CheckPositiveAck task calls with a loadable queue of 16-bit Knight commands. The engine issues each command with the send_cmd/cmd_sent handshake, waits for the 8-bit response, and checks it against the positive-ack code. It stops on the first bad response or timeout and reports status for bench scoreboards or a hardware self-test.

---
 rtl/cmd_seq_player_if.sv | 26 ++
 rtl/cmd_seq_player.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_seq_player_if.sv
// cmd_seq_player_if: command/response handshake between the sequence player
// and RemoteComm. The player drives cmd/send_cmd and receives the transmit
// completion and the response byte.
interface cmd_seq_player_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/cmd_seq_player.sv
// cmd_seq_player: replayable queue of 16-bit Knight commands. Each entry is
// sent to RemoteComm, then its response byte is checked against ACK_CODE.
// The sequence stops on the first bad response or response timeout.
// Optional build macro CMD_SEQ_RETRY_EN: a timed-out command is re-issued once
// before the timeout is reported.
module cmd_seq_player #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  ACK_CODE   = 8'hA5,
  parameter int unsigned TMO_CYCLES = 2**24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_cmd,
  input  logic                     start,
  input  logic                     abort,
  cmd_seq_player_if.master         bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [$clog2(DEPTH):0]   num_cmds,
  output logic                     full
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TMO_CYCLES);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  // Command storage
  logic [15:0]   mem [DEPTH];
  logic [IW-1:0] wr_ptr;
  logic          push_c;

  // FSM state and registered outputs
  state_t        state, state_nxt;
  logic [15:0]   cmd_q, cmd_nxt;
  logic          send_cmd_q, send_cmd_nxt;
  logic          busy_nxt, done_nxt, err_nxt;
  logic [1:0]    err_code_nxt;
  logic [IW-1:0] err_idx_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [IW-1:0] idx_inc_c;
  logic [TW-1:0] timer, timer_nxt;
  logic          seen_low, seen_low_nxt;
  logic          abort_q, abort_q_nxt;
`ifdef CMD_SEQ_RETRY_EN
  logic          retry_q, retry_nxt;
`endif

  assign bus.cmd      = cmd_q;
  assign bus.send_cmd = send_cmd_q;

  // Pushes are only taken while idle and when there is room
  assign push_c    = wr_en && !full && !busy;
  assign idx_inc_c = idx + IW'(1);

  // Queue storage write port (contents need no reset; num_cmds gates use)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_cmd;
    end
  end

  // Queue write pointer, occupancy and full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      num_cmds <= '0;
      full     <= 1'b0;
    end else if (push_c) begin
      wr_ptr   <= wr_ptr + IW'(1);
      num_cmds <= num_cmds + CW'(1);
      full     <= (num_cmds + CW'(1)) == DEPTH_C;
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      send_cmd_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      err_idx    <= '0;
      idx        <= '0;
      timer      <= '0;
      seen_low   <= 1'b0;
      abort_q    <= 1'b0;
`ifdef CMD_SEQ_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_nxt;
      send_cmd_q <= send_cmd_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
      err_idx    <= err_idx_nxt;
      idx        <= idx_nxt;
      timer      <= timer_nxt;
      seen_low   <= seen_low_nxt;
      abort_q    <= abort_q_nxt;
`ifdef CMD_SEQ_RETRY_EN
      retry_q    <= retry_nxt;
`endif
    end
  end

  // Next-state and output decode; send_cmd is raised on entry to ISSUE so the
  // pulse coincides with the ISSUE cycle
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    send_cmd_nxt = 1'b0;
    busy_nxt     = busy;
    done_nxt     = done;
    err_nxt      = err;
    err_code_nxt = err_code;
    err_idx_nxt  = err_idx;
    idx_nxt      = idx;
    timer_nxt    = timer;
    seen_low_nxt = seen_low;
    abort_q_nxt  = abort_q | abort;
`ifdef CMD_SEQ_RETRY_EN
    retry_nxt    = retry_q;
`endif

    case (state)
      S_IDLE: begin
        abort_q_nxt = 1'b0;
        if (abort) begin
          state_nxt    = S_DONE;
          done_nxt     = 1'b1;
          err_nxt      = 1'b0;
          err_code_nxt = ERR_NONE;
        end else if (start) begin
          done_nxt     = 1'b0;
          err_nxt      = 1'b0;
          err_code_nxt = ERR_NONE;
          idx_nxt      = '0;
          if (num_cmds == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt    = S_ISSUE;
            busy_nxt     = 1'b1;
            send_cmd_nxt = 1'b1;
            cmd_nxt      = mem[IW'(0)];
`ifdef CMD_SEQ_RETRY_EN
            retry_nxt    = 1'b0;
`endif
          end
        end
      end

      S_ISSUE: begin
        seen_low_nxt = !bus.cmd_sent;
        state_nxt    = S_WAIT_SENT;
      end

      // Only a low-to-high transition of cmd_sent after the issue counts
      S_WAIT_SENT: begin
        if (!bus.cmd_sent) begin
          seen_low_nxt = 1'b1;
        end else if (seen_low) begin
          timer_nxt = '0;
          state_nxt = S_WAIT_RESP;
        end
      end

      // A response on the terminal-count cycle takes priority over timeout
      S_WAIT_RESP: begin
        if (bus.resp_rdy) begin
          if (bus.resp == ACK_CODE) begin
            state_nxt = S_NEXT;
          end else begin
            state_nxt    = S_ERR;
            busy_nxt     = 1'b0;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_RESP;
            err_idx_nxt  = idx;
            abort_q_nxt  = 1'b0;
          end
        end else if (timer == TMO_LAST) begin
`ifdef CMD_SEQ_RETRY_EN
          if (!retry_q) begin
            retry_nxt    = 1'b1;
            timer_nxt    = '0;
            state_nxt    = S_ISSUE;
            send_cmd_nxt = 1'b1;
            cmd_nxt      = mem[idx];
          end else begin
            state_nxt    = S_ERR;
            busy_nxt     = 1'b0;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_TMO;
            err_idx_nxt  = idx;
            abort_q_nxt  = 1'b0;
          end
`else
          state_nxt    = S_ERR;
          busy_nxt     = 1'b0;
          err_nxt      = 1'b1;
          err_code_nxt = ERR_TMO;
          err_idx_nxt  = idx;
          abort_q_nxt  = 1'b0;
`endif
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      // Advance, or finish on last entry or a pending abort
      S_NEXT: begin
        idx_nxt = idx_inc_c;
        if (((CW'(idx) + CW'(1)) == num_cmds) || abort_q || abort) begin
          state_nxt   = S_DONE;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          abort_q_nxt = 1'b0;
        end else begin
          state_nxt    = S_ISSUE;
          send_cmd_nxt = 1'b1;
          cmd_nxt      = mem[idx_inc_c];
`ifdef CMD_SEQ_RETRY_EN
          retry_nxt    = 1'b0;
`endif
        end
      end

      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
